multi_sprite_engine: RTL and testbench
======================================

MULTI_SPRITE_ENGINE -- requirements
Module: multi_sprite_engine

Interface
REQ-001 Parameter N_SPR, default 2: number of independent sprites (1..8).
REQ-002 Parameter SIZE, default 4: sprite edge in pixels, a power of two (2..16).
REQ-003 Parameters XW = 8 and YW = 7, defaults: coordinate widths.
REQ-004 Parameters X_MAX = 159 and Y_MAX = 119, defaults: last valid screen pixel.
REQ-005 Parameter CW, default 3: colour width.
REQ-006 Port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-007 Port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-008 Port tick, input, 1 bit: single-cycle move strobe from the rate divider.
REQ-009 Port dir, input, 4*N_SPR bits: per sprite i, bits [4i+3:4i] are {left, down, up, right}.
REQ-010 Port colour_in, input, CW*N_SPR bits: draw colour per sprite.
REQ-011 Ports start_x (XW*N_SPR bits) and start_y (YW*N_SPR bits), inputs: positions loaded at reset.
REQ-012 Port plot_ready, input, 1 bit: pixel sink accepts the current pixel.
REQ-013 Ports x_out (XW), y_out (YW), c_out (CW), outputs: current pixel.
REQ-014 Port plot, output, 1 bit: pixel valid.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 FSM states: INIT, IDLE, SCAN, ERASE, MOVE, DRAW.
REQ-017 INIT: draw every sprite in index order at its loaded position, then go to IDLE.
REQ-018 IDLE and tick=1: capture dir into a snapshot register, set sprite index to 0, go to SCAN.
REQ-019 A tick arriving while busy=1 is dropped; it is neither queued nor counted.
REQ-020 SCAN: if the snapshot nibble for the current index is zero, or its net motion is zero, advance the index; otherwise go to ERASE.
REQ-021 SCAN after index N_SPR-1: return to IDLE.
REQ-022 ERASE: emit SIZE*SIZE pixels at the old position with c_out = 0, then go to MOVE.
REQ-023 MOVE (one cycle): apply right +1, left -1, down +1, up -1.
REQ-024 In MOVE, opposite bits that are both set cancel on that axis.
REQ-025 In MOVE, clamp x to 0..X_MAX-SIZE+1 and y to 0..Y_MAX-SIZE+1; a move past either edge leaves the coordinate unchanged.
REQ-026 DRAW: emit SIZE*SIZE pixels at the new position with colour_in for that sprite, advance the index, then go to SCAN.
REQ-027 Pixel order: offset counter of 2*log2(SIZE) bits; low half is the x offset, high half is the y offset, scanned row-major from (0,0).
REQ-028 Handshake: plot, x_out, y_out and c_out are held stable until the cycle where plot and plot_ready are both 1; the offset advances only in that cycle.
REQ-029 A pass completes on the acceptance of pixel SIZE*SIZE-1; the FSM changes state in the next cycle with no idle bubble.
REQ-030 plot is 0 in IDLE, SCAN and MOVE.
REQ-031 Coordinate arithmetic is XW/YW bits wide; clamping guarantees that base+offset never wraps.
REQ-032 colour_in is sampled per pixel; dir is sampled only at the IDLE-to-SCAN transition.

Reset
REQ-033 resetn=0 at a clock edge: load positions from start_x/start_y and clear the offset, index and snapshot.
REQ-034 resetn=0 at a clock edge: set plot=0, x_out=y_out=c_out=0 and busy=1, and enter INIT.
REQ-035 Reset asserted mid-pass aborts that pass immediately; no further pixels from the aborted pass are emitted.

Structure
REQ-036 A shared package holds the state enumeration, the direction bit indices (RIGHT=0, UP=1, DOWN=2, LEFT=3) and the default screen limits.
REQ-037 Sub-module block_scanner (offset counter, handshake and done flag) is instantiated once and reused by the INIT, ERASE and DRAW passes.

Verification
REQ-038 Reset with start (10,20), plot_ready=1: expect 16 INIT pixels from (10,20) to (13,23), then busy=0.
REQ-039 tick with dir0=0001: expect 16 pixels with c=0 at x 10..13, then 16 pixels at x 11..14 with colour_in, then IDLE.
REQ-040 Sprite at x=156 with right held: expect position to stay at 156; erase and redraw still occur at the same place.
REQ-041 plot_ready toggling 1/0 each cycle: expect each pixel held while ready=0 and exactly 32 accepted pixels per moved sprite.
REQ-042 N_SPR=2 with dir0=0000, dir1=1000 and a second tick mid-pass: expect only sprite 1 processed and the second tick ignored.
REQ-043 resetn pulsed low during DRAW: expect plot=0 on the next cycle, then a restart at INIT from the start positions.

Source files
------------

// File: rtl/multi_sprite_engine_pkg.sv
// Shared definitions for the multi-sprite engine: FSM states, the bit positions
// inside each direction nibble, and the default screen limits.
package multi_sprite_engine_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SCAN,
        S_ERASE,
        S_MOVE,
        S_DRAW
    } state_t;

    localparam int unsigned DIR_RIGHT = 0;
    localparam int unsigned DIR_UP    = 1;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 3;

    localparam int unsigned DEF_X_MAX = 159;
    localparam int unsigned DEF_Y_MAX = 119;

endpackage

// File: rtl/multi_sprite_engine_scanner.sv
// Walks the SIZE x SIZE offsets of one sprite block row-major, advancing only
// when the pixel sink accepts the current pixel.
module block_scanner #(
    parameter int unsigned SIZE = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    ready,
    output logic                    valid,
    output logic                    done,
    output logic [$clog2(SIZE)-1:0] next_x,
    output logic [$clog2(SIZE)-1:0] next_y
);
    localparam int unsigned LW = $clog2(SIZE);
    localparam logic [2*LW-1:0] ONE = 1;

    logic [2*LW-1:0] off;
    logic [2*LW-1:0] off_nxt;
    logic            fire;

    assign fire = valid && ready;
    assign done = fire && (off == '1);

    // The owner registers its pixel outputs from the offset this block will hold next.
    always_comb begin
        off_nxt = off;
        if (start)
            off_nxt = '0;
        else if (fire)
            off_nxt = off + ONE;
    end

    assign next_x = off_nxt[LW-1:0];
    assign next_y = off_nxt[2*LW-1:LW];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            off   <= '0;
            valid <= 1'b0;
        end else begin
            off <= off_nxt;
            if (start)
                valid <= 1'b1;
            else if (done)
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_sprite_engine.sv
// Moves N_SPR square sprites on tick strobes, erasing each moved sprite and
// redrawing it at its clamped new position through a ready/valid pixel port.
module multi_sprite_engine
    import multi_sprite_engine_pkg::*;
#(
    parameter int unsigned N_SPR = 2,
    parameter int unsigned SIZE  = 4,
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 7,
    parameter int unsigned X_MAX = DEF_X_MAX,
    parameter int unsigned Y_MAX = DEF_Y_MAX,
    parameter int unsigned CW    = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  tick,
    input  logic [4*N_SPR-1:0]    dir,
    input  logic [CW*N_SPR-1:0]   colour_in,
    input  logic [XW*N_SPR-1:0]   start_x,
    input  logic [YW*N_SPR-1:0]   start_y,
    input  logic                  plot_ready,
    output logic [XW-1:0]         x_out,
    output logic [YW-1:0]         y_out,
    output logic [CW-1:0]         c_out,
    output logic                  plot,
    output logic                  busy
);
    localparam int unsigned LW = $clog2(SIZE);
    localparam int unsigned IW = $clog2(N_SPR + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SPR - 1);
    localparam logic [IW-1:0] N_IDX    = IW'(N_SPR);
    localparam logic [XW-1:0] X_LIM    = XW'(X_MAX - SIZE + 1);
    localparam logic [YW-1:0] Y_LIM    = YW'(Y_MAX - SIZE + 1);

    state_t              state;
    logic [IW-1:0]       idx;
    logic [4*N_SPR-1:0]  snap;
    logic                init_pend;
    logic [XW-1:0]       pos_x [N_SPR];
    logic [YW-1:0]       pos_y [N_SPR];

    logic                start, done, fire, load, moving;
    logic [LW-1:0]       nxt_x, nxt_y;
    logic [IW-1:0]       sel_idx;
    logic [XW-1:0]       sel_x, new_x, base_x;
    logic [YW-1:0]       sel_y, new_y, base_y;
    logic [CW-1:0]       sel_c, load_c;
    logic [3:0]          cur_nib;

    block_scanner #(.SIZE(SIZE)) u_scanner (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .ready  (plot_ready),
        .valid  (plot),
        .done   (done),
        .next_x (nxt_x),
        .next_y (nxt_y)
    );

    assign fire = plot && plot_ready;
    assign load = start || (fire && !done);

    // INIT chains sprites back to back, so the next pass loads sprite idx+1 in the done cycle.
    always_comb begin
        sel_idx = idx;
        if (state == S_INIT && done && idx != LAST_IDX)
            sel_idx = idx + IW'(1);
    end

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_c   = '0;
        cur_nib = '0;
        for (int unsigned i = 0; i < N_SPR; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_x = pos_x[i];
                sel_y = pos_y[i];
                sel_c = colour_in[CW*i +: CW];
            end
            if (idx == IW'(i))
                cur_nib = snap[4*i +: 4];
        end
    end

    assign moving = (cur_nib[DIR_RIGHT] ^ cur_nib[DIR_LEFT]) ||
                    (cur_nib[DIR_UP] ^ cur_nib[DIR_DOWN]);

    always_comb begin
        new_x = sel_x;
        new_y = sel_y;
        if (cur_nib[DIR_RIGHT] && !cur_nib[DIR_LEFT] && sel_x < X_LIM)
            new_x = sel_x + XW'(1);
        else if (cur_nib[DIR_LEFT] && !cur_nib[DIR_RIGHT] && sel_x != '0)
            new_x = sel_x - XW'(1);
        if (cur_nib[DIR_DOWN] && !cur_nib[DIR_UP] && sel_y < Y_LIM)
            new_y = sel_y + YW'(1);
        else if (cur_nib[DIR_UP] && !cur_nib[DIR_DOWN] && sel_y != '0)
            new_y = sel_y - YW'(1);
    end

    // The DRAW pass starts in MOVE, before the new position has been written back.
    assign base_x = (state == S_MOVE) ? new_x : sel_x;
    assign base_y = (state == S_MOVE) ? new_y : sel_y;
    assign load_c = (state == S_SCAN || state == S_ERASE) ? '0 : sel_c;

    always_comb begin
        start = 1'b0;
        case (state)
            S_INIT:  start = init_pend || (done && idx != LAST_IDX);
            S_SCAN:  start = (idx != N_IDX) && moving;
            S_MOVE:  start = 1'b1;
            default: start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_INIT;
            idx       <= '0;
            snap      <= '0;
            init_pend <= 1'b1;
            busy      <= 1'b1;
            x_out     <= '0;
            y_out     <= '0;
            c_out     <= '0;
            for (int unsigned i = 0; i < N_SPR; i++) begin
                pos_x[i] <= start_x[XW*i +: XW];
                pos_y[i] <= start_y[YW*i +: YW];
            end
        end else begin
            init_pend <= 1'b0;
            if (load) begin
                x_out <= base_x + XW'(nxt_x);
                y_out <= base_y + YW'(nxt_y);
                c_out <= load_c;
            end
            case (state)
                S_INIT: begin
                    if (done) begin
                        if (idx == LAST_IDX) begin
                            state <= S_IDLE;
                            idx   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_IDLE: begin
                    if (tick) begin
                        snap  <= dir;
                        idx   <= '0;
                        state <= S_SCAN;
                        busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (idx == N_IDX) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (moving) begin
                        state <= S_ERASE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_ERASE: begin
                    if (done)
                        state <= S_MOVE;
                end
                S_MOVE: begin
                    for (int unsigned i = 0; i < N_SPR; i++) begin
                        if (idx == IW'(i)) begin
                            pos_x[i] <= new_x;
                            pos_y[i] <= new_y;
                        end
                    end
                    state <= S_DRAW;
                end
                S_DRAW: begin
                    if (done) begin
                        idx   <= idx + IW'(1);
                        state <= S_SCAN;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_sprite_engine.sv
// Directed bench for multi_sprite_engine: a table of sprite-0 moves plus
// hand-written sequences for clamping, dropped ticks, backpressure and reset.
module tb_multi_sprite_engine;
    localparam int N_SPR = 2;
    localparam int SIZE  = 4;
    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int CW    = 3;
    localparam logic [CW-1:0] COL0 = 3'd5;
    localparam logic [CW-1:0] COL1 = 3'd2;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                tick = 1'b0;
    logic                plot_ready = 1'b1;
    logic [4*N_SPR-1:0]  dir = '0;
    logic [CW*N_SPR-1:0] colour_in = {COL1, COL0};
    logic [XW*N_SPR-1:0] start_x = '0;
    logic [YW*N_SPR-1:0] start_y = '0;
    logic [XW-1:0]       x_out;
    logic [YW-1:0]       y_out;
    logic [CW-1:0]       c_out;
    logic                plot, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] d0;
        bit         tog;
        int         ox, oy, nx, ny;
        bit         moves;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    multi_sprite_engine #(
        .N_SPR (N_SPR),
        .SIZE  (SIZE),
        .XW    (XW),
        .YW    (YW),
        .X_MAX (159),
        .Y_MAX (119),
        .CW    (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .tick       (tick),
        .dir        (dir),
        .colour_in  (colour_in),
        .start_x    (start_x),
        .start_y    (start_y),
        .plot_ready (plot_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .c_out      (c_out),
        .plot       (plot),
        .busy       (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Collects one SIZE*SIZE pass and checks every accepted pixel against the raster.
    task automatic run_pass(input string nm, input int bx, input int by, input logic [CW-1:0] bc,
                            input bit tog, input int tick_at);
        int k = 0;
        int cyc = 0;
        bit r = 1'b1;
        bit held = 1'b0;
        logic [XW+YW+CW-1:0] hv = '0;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        while (k < SIZE*SIZE && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == tick_at) begin
                tick = 1'b1;
                dir  = 8'h11;
            end else if (cyc == tick_at + 1) begin
                tick = 1'b0;
            end
            if (held) begin
                check($sformatf("%s hold px%0d", nm, k), 32'({plot, x_out, y_out, c_out}), 32'({1'b1, hv}));
                held = 1'b0;
            end
            if (tog) r = ~r;
            plot_ready = r;
            if (plot && r) begin
                ex = XW'(bx + k % SIZE);
                ey = YW'(by + k / SIZE);
                check($sformatf("%s px%0d", nm, k), 32'({x_out, y_out, c_out}), 32'({ex, ey, bc}));
                k++;
            end else if (plot) begin
                held = 1'b1;
                hv = {x_out, y_out, c_out};
            end
        end
        tick = 1'b0;
        if (k < SIZE*SIZE)
            check($sformatf("%s timeout pixel count", nm), 32'(k), 32'(SIZE*SIZE));
        plot_ready = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        int cyc = 0;
        bit saw = 1'b0;
        @(negedge clk);
        while (busy && cyc < 100) begin
            if (plot) saw = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (plot) saw = 1'b1;
        check({nm, " idle"}, 32'(busy), 32'(0));
        check({nm, " no extra plot"}, 32'(saw), 32'(0));
    endtask

    task automatic do_tick(input logic [4*N_SPR-1:0] d);
        @(negedge clk);
        check("idle before tick", 32'(busy), 32'(0));
        dir  = d;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset(input int x0, input int y0, input int x1, input int y1);
        @(negedge clk);
        resetn  = 1'b0;
        tick    = 1'b0;
        start_x = {XW'(x1), XW'(x0)};
        start_y = {YW'(y1), YW'(y0)};
        @(negedge clk);
        check("reset plot", 32'(plot), 32'(0));
        check("reset busy", 32'(busy), 32'(1));
        check("reset xyc", 32'({x_out, y_out, c_out}), 32'(0));
        resetn = 1'b1;
        run_pass("init0", x0, y0, COL0, 1'b0, -1);
        run_pass("init1", x1, y1, COL1, 1'b0, -1);
        wait_idle("init");
    endtask

    initial begin
        int cyc;
        bit saw;

        vecs[0] = '{4'b0001, 1'b0, 10, 20, 11, 20, 1'b1};
        vecs[1] = '{4'b0100, 1'b1, 11, 20, 11, 21, 1'b1};
        vecs[2] = '{4'b0010, 1'b0, 11, 21, 11, 20, 1'b1};
        vecs[3] = '{4'b1000, 1'b1, 11, 20, 10, 20, 1'b1};
        vecs[4] = '{4'b0101, 1'b0, 10, 20, 11, 21, 1'b1};
        vecs[5] = '{4'b1011, 1'b0, 11, 21, 11, 20, 1'b1};
        vecs[6] = '{4'b1111, 1'b0, 11, 20, 11, 20, 1'b0};
        vecs[7] = '{4'b0111, 1'b1, 11, 20, 12, 20, 1'b1};
        vecs[8] = '{4'b0000, 1'b0, 12, 20, 12, 20, 1'b0};
        vecs[9] = '{4'b1010, 1'b0, 12, 20, 11, 19, 1'b1};

        do_reset(10, 20, 100, 50);

        for (int i = 0; i < 10; i++) begin
            do_tick({4'b0000, vecs[i].d0});
            if (vecs[i].moves) begin
                run_pass($sformatf("v%0d erase", i), vecs[i].ox, vecs[i].oy, 3'd0, vecs[i].tog, -1);
                run_pass($sformatf("v%0d draw", i), vecs[i].nx, vecs[i].ny, COL0, vecs[i].tog, -1);
            end
            wait_idle($sformatf("v%0d", i));
        end

        // Only sprite 1 moves; a tick during its erase pass must vanish.
        do_tick(8'h80);
        run_pass("s1 erase", 100, 50, 3'd0, 1'b0, 3);
        run_pass("s1 draw", 99, 50, COL1, 1'b0, -1);
        wait_idle("s1");
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (plot || busy) saw = 1'b1;
        end
        check("dropped tick quiet", 32'(saw), 32'(0));

        // Both sprites pinned at screen edges.
        do_reset(156, 0, 0, 116);
        do_tick(8'hC3);
        run_pass("clamp s0 erase", 156, 0, 3'd0, 1'b0, -1);
        run_pass("clamp s0 draw", 156, 0, COL0, 1'b0, -1);
        run_pass("clamp s1 erase", 0, 116, 3'd0, 1'b0, -1);
        run_pass("clamp s1 draw", 0, 116, COL1, 1'b0, -1);
        wait_idle("clamp");
        do_tick(8'h01);
        run_pass("right held erase", 156, 0, 3'd0, 1'b1, -1);
        run_pass("right held draw", 156, 0, COL0, 1'b1, -1);
        wait_idle("right held");
        do_tick(8'h08);
        run_pass("left erase", 156, 0, 3'd0, 1'b0, -1);
        run_pass("left draw", 155, 0, COL0, 1'b0, -1);
        wait_idle("left");

        // Reset in the middle of a DRAW pass.
        do_reset(10, 20, 100, 50);
        do_tick(8'h01);
        run_pass("mid erase", 10, 20, 3'd0, 1'b0, -1);
        cyc = 0;
        while (!plot && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mid draw started", 32'(plot), 32'(1));
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort plot", 32'(plot), 32'(0));
        check("abort busy", 32'(busy), 32'(1));
        check("abort xyc", 32'({x_out, y_out, c_out}), 32'(0));
        resetn = 1'b1;
        run_pass("restart init0", 10, 20, COL0, 1'b0, -1);
        run_pass("restart init1", 100, 50, COL1, 1'b0, -1);
        wait_idle("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
